// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-load arbiter.
//   arb_state_e  : FSM encoding (IDLE / GRANTED)
//   DEF_*        : default parameter values
//   idx_width()  : bits needed to index n items (minimum 1)
package reg_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOCK_MAX = 8;

  // Width of an index able to hold 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req    : request vector, one bit per requester
//   ptr    : index with highest priority this cycle (always < N_REQ)
//   valid  : at least one request present
//   winner : first set request searching ptr, ptr+1, ... wrapping at N_REQ
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IW   = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    winner
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down to ptr itself, so the last hit
  // written is the closest one to ptr. The wrap is a single subtract
  // because ptr + offset < 2*N_REQ, which keeps indices below N_REQ.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N_REQ)) sum = sum - (IW + 1)'(N_REQ);
      idx = sum[IW-1:0];
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Shared WIDTH-bit storage register with round-robin write arbitration
// between N_REQ requesters (req/grant/ack handshake).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req        : per-requester write request, held until ack
//   wdata      : flattened write data, requester i at [i*WIDTH +: WIDTH]
//   lock       : per-requester burst lock (only with REG_ARB_LOCK_EN)
//   grant      : one-hot current owner, zero when idle
//   ack        : one-cycle pulse to the requester whose word was loaded
//   q          : register contents
//   busy       : high while GRANTED; this is also the FSM state bit
//   owner      : index of the current or most recent grantee
// Handshake: a requester is granted from IDLE, and at the following edge its
// word is loaded and acked if req is still high (otherwise the grant is
// aborted). The acked requester drops req in the ack cycle; ack masks its
// request for that one edge so it cannot be granted twice.
// Optional macro REG_ARB_LOCK_EN adds the lock input: a locked owner keeps
// the grant and may write every cycle, up to LOCK_MAX consecutive writes.
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WIDTH-1:0]      wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]            lock,
`endif
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            ack,
  output logic [WIDTH-1:0]            q,
  output logic                        busy,
  output logic [idx_width(N_REQ)-1:0] owner
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = idx_width(LOCK_MAX);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ - 1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;
  logic [N_REQ-1:0] ack_q;
  logic [CW-1:0]    lock_cnt_q;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             load;
  logic             lock_hit;
  logic             stay_locked;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req & ~ack_q),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef REG_ARB_LOCK_EN
  assign lock_hit = lock[owner_q];
`else
  assign lock_hit = 1'b0;
`endif

  // Hold the grant after this write only while the burst has room left.
  assign stay_locked = lock_hit && (lock_cnt_q < CW'(LOCK_MAX - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and load decision.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = GRANTED;
      end
      GRANTED: begin
        if (req[owner_q]) begin
          load = 1'b1;
          if (!stay_locked) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state and owner registers.
  always_comb begin
    busy  = (state_q == GRANTED);
    grant = busy ? (ONE << owner_q) : '0;
    ack   = ack_q;
    owner = owner_q;
  end

  // Datapath: owner, pointer, storage register, ack pulse, burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= '0;
      ptr_q      <= '0;
      q          <= '0;
      ack_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      ack_q <= '0;
      if (state_q == IDLE && pick_valid) owner_q <= pick_idx;
      if (load) begin
        q     <= wdata[owner_q*WIDTH +: WIDTH];
        ack_q <= ONE << owner_q;
        if (!stay_locked)
          ptr_q <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      // The burst count survives only across locked writes; any release
      // or abort clears it.
      if (state_q == GRANTED)
        lock_cnt_q <= (load && stay_locked) ? lock_cnt_q + 1'b1 : '0;
    end
  end

endmodule
